adc_channel_sampler: RTL and testbench
======================================

// Module: adc_channel_sampler
// PURPOSE
//  Downstream of the mux address sequencer. On each rising edge of i640, latches
//  the current mux address ADR and bank select SEL, then waits for the analog mux
//  to settle. It then reads one sample from a serial ADC (CS/SCLK/SDO, MSB first)
//  and pushes {SEL, ADR, sample} into a small FWFT FIFO for the telemetry framer.
// PARAMETERS
//  SETTLE_CYC  16  clk cycles between address latch and ADC CS assertion (>=1)
//  SCLK_DIV    4   clk cycles per SCLK half-period (>=1)
//  DATA_W      12  ADC sample width, bits
//  FIFO_AW     3   FIFO address width; depth = 2**FIFO_AW = 8
// PORTS
//  clk        in   1          system clock; all logic on posedge
//  reset      in   1          synchronous, active-high reset
//  i640       in   1          word strobe, synchronous to clk; rising edge starts a sample
//  ADR        in   7          mux address, stable from i640 rise for >= SETTLE_CYC
//  SEL        in   1          mux bank select, latched together with ADR
//  adc_cs_n   out  1          ADC chip select, active low
//  adc_sclk   out  1          ADC serial clock, idles low
//  adc_sdo    in   1          ADC serial data, valid on SCLK rising edge
//  out_data   out  8+DATA_W   {SEL, ADR[6:0], sample[DATA_W-1:0]} at FIFO head
//  out_valid  out  1          FIFO not empty
//  out_ready  in   1          consumer pop; pops the head when out_valid=1
//  busy       out  1          FSM not in IDLE
//  ovf        out  1          sticky: sample dropped because FIFO was full
//  miss       out  1          sticky: i640 rise while busy (strobe ignored)
//  clr_flags  in   1          clears ovf and miss for one cycle
// BEHAVIOUR
//  Reset: state=IDLE, FIFO emptied, adc_cs_n=1, adc_sclk=0, out_valid=0, busy=0,
//   ovf=0, miss=0, i640 delay register=1. Reset mid-conversion aborts the read:
//   CS is released on the next edge and no partial word is pushed.
//  Edge detection: rise = i640 & ~i640_d, where i640_d is registered each cycle.
//  FSM transitions:
//   IDLE   -> SETTLE on rise; latch ADR and SEL; counter := 0.
//   SETTLE -> CONV after SETTLE_CYC cycles in SETTLE; on entry, adc_cs_n := 0.
//   CONV   -> PUSH. CONV lasts exactly DATA_W*2*SCLK_DIV cycles. Each bit period is
//    SCLK low for SCLK_DIV cycles, then high for SCLK_DIV cycles. adc_sdo is shifted
//    into the LSB on the cycle SCLK goes high, so the first bit captured is the MSB.
//   PUSH   -> IDLE. adc_cs_n := 1; adc_sclk is already 0. Write the word if the FIFO
//    is not full, or if it is full and out_ready=1 in the same cycle (pop then push).
//    Otherwise drop the word and set ovf.
//  Latency: out_valid (empty FIFO) rises SETTLE_CYC + 2*SCLK_DIV*DATA_W + 2 cycles
//   after the cycle rise is seen; with defaults, 114 cycles.
//  miss: set on any rise seen while busy=1; that strobe is discarded, not queued.
//  clr_flags: if a set event and clr_flags occur in the same cycle, the set wins.
//  FIFO: first-word fall-through; pointers wrap modulo depth; a count of FIFO_AW+1
//   bits distinguishes full from empty. A pop while empty is ignored.
//  Outputs: adc_cs_n and adc_sclk are registered (glitch-free); out_data is the
//   registered FIFO head.
// TESTING
//  1 Single strobe, ADR=7'h05, SEL=1, ADC model returns 12'hA5C
//    -> out_data=20'h85A5C with out_valid at cycle +114;
//    SCLK shows 12 pulses with 4-cycle high phases; CS low for 96 cycles.
//  2 Eight strobes with out_ready=0, then a ninth -> FIFO full after 8 words;
//    ovf=1 after the ninth PUSH; the 8 words drain in order, ADR 0..7.
//  3 Second i640 rise 50 cycles after the first -> miss=1, exactly one word pushed;
//    clr_flags pulse -> miss=0.
//  4 reset asserted at cycle 60 of CONV -> adc_cs_n=1 and adc_sclk=0 next cycle;
//    out_valid stays 0; the next strobe produces a correct word.
//  5 FIFO full with out_ready=1 held at PUSH -> word accepted, ovf stays 0,
//    count unchanged at 8.
//  6 ADR sweep 0..127 with SEL toggling at wrap -> 128 words, each tagged with the
//    ADR/SEL latched at its own strobe.

Source files
------------

// File: rtl/adc_channel_sampler.sv
// rtl/adc_channel_sampler.sv - strobe-triggered serial ADC sampler with FWFT output FIFO
//
// Purpose: on each rising edge of i640, latch ADR/SEL, wait SETTLE_CYC cycles for
// the analog mux to settle, then read DATA_W bits MSB-first from a serial ADC.
// The result {SEL, ADR, sample} is pushed into a first-word-fall-through FIFO.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   i640                   word strobe; a rising edge starts one sample
//   ADR, SEL               mux address and bank select, latched at the strobe
//   adc_cs_n, adc_sclk     registered ADC chip select (active low) and serial clock
//   adc_sdo                ADC serial data, sampled while SCLK is high
//   out_data, out_valid    FIFO head word and FIFO-not-empty
//   out_ready              consumer pop
//   busy                   sampler FSM not idle
//   ovf, miss              sticky flags: word dropped on full FIFO / strobe while busy
//   clr_flags              clears ovf and miss (a simultaneous set wins)

module adc_channel_sampler #(
  parameter int SETTLE_CYC = 16,
  parameter int SCLK_DIV   = 4,
  parameter int DATA_W     = 12,
  parameter int FIFO_AW    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i640,
  input  logic [6:0]          ADR,
  input  logic                SEL,
  output logic                adc_cs_n,
  output logic                adc_sclk,
  input  logic                adc_sdo,
  output logic [8+DATA_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                ovf,
  output logic                miss,
  input  logic                clr_flags
);

  localparam int PERIOD   = 2 * SCLK_DIV;
  localparam int CONV_CYC = DATA_W * PERIOD;
  localparam int CNT_MAX  = (CONV_CYC > SETTLE_CYC) ? CONV_CYC : SETTLE_CYC;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int DEPTH    = 1 << FIFO_AW;
  localparam int WORD_W   = 8 + DATA_W;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CONV, S_PUSH} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               i640_dly_q, i640_dly_d;
  logic [6:0]         adr_q, adr_d;
  logic               sel_q, sel_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               cs_n_q, cs_n_d;
  logic               sclk_q, sclk_d;
  logic               ovf_q, ovf_d;
  logic               miss_q, miss_d;
  logic [WORD_W-1:0]  mem_q [DEPTH];
  logic [WORD_W-1:0]  mem_d [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;

  logic rise, settle_done, conv_done;
  logic fifo_full, fifo_empty, push_ok, do_push, do_pop;

  assign rise        = i640 & ~i640_dly_q;
  assign settle_done = (cnt_q == CNT_W'(SETTLE_CYC - 1));
  assign conv_done   = (cnt_q == CNT_W'(CONV_CYC - 1));
  assign fifo_full   = (count_q == (FIFO_AW+1)'(DEPTH));
  assign fifo_empty  = (count_q == '0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; cnt counts cycles spent in SETTLE and CONV
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
      end
      S_SETTLE: begin
        if (settle_done) begin
          state_d = S_CONV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CONV: begin
        if (conv_done) begin
          state_d = S_PUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PUSH:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic. CS and SCLK are decoded from the next state/count so the
  // registered pins line up exactly with the CONV cycles: CS is low for all of
  // CONV and already high in PUSH; each bit is K cycles low then K cycles high.
  always_comb begin
    cs_n_d = (state_d != S_CONV);
    sclk_d = (state_d == S_CONV) &&
             ((cnt_d % CNT_W'(PERIOD)) >= CNT_W'(SCLK_DIV));
  end

  assign busy = (state_q != S_IDLE);

  // Datapath: strobe latch, shift register, sticky flags and FIFO
  always_comb begin
    i640_dly_d = i640;
    adr_d      = adr_q;
    sel_d      = sel_q;
    shift_d    = shift_q;
    if (state_q == S_IDLE && rise) begin
      adr_d = ADR;
      sel_d = SEL;
    end
    // First cycle with SCLK high in each bit period: sample SDO into the LSB
    if (state_q == S_CONV && (cnt_q % CNT_W'(PERIOD)) == CNT_W'(SCLK_DIV)) begin
      shift_d = {shift_q[DATA_W-2:0], adc_sdo};
    end

    // A full FIFO still accepts the word when the head is popped in the same cycle
    push_ok = !fifo_full || out_ready;
    do_push = (state_q == S_PUSH) && push_ok;
    do_pop  = out_ready && !fifo_empty;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = {sel_q, adr_q, shift_q};
      wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
      2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
      default: count_d = count_q;
    endcase

    // Set has priority over clear
    if (state_q == S_PUSH && !push_ok) ovf_d = 1'b1;
    else if (clr_flags)                ovf_d = 1'b0;
    else                               ovf_d = ovf_q;

    if (rise && state_q != S_IDLE)     miss_d = 1'b1;
    else if (clr_flags)                miss_d = 1'b0;
    else                               miss_d = miss_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      i640_dly_q <= 1'b1;
      adr_q      <= '0;
      sel_q      <= 1'b0;
      shift_q    <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      ovf_q      <= 1'b0;
      miss_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      i640_dly_q <= i640_dly_d;
      adr_q      <= adr_d;
      sel_q      <= sel_d;
      shift_q    <= shift_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      ovf_q      <= ovf_d;
      miss_q     <= miss_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible once counted in
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign adc_cs_n  = cs_n_q;
  assign adc_sclk  = sclk_q;
  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = !fifo_empty;
  assign ovf       = ovf_q;
  assign miss      = miss_q;

endmodule

// File: tb/tb_adc_channel_sampler.sv
// tb/tb_adc_channel_sampler.sv - randomized self-checking bench for adc_channel_sampler

module tb_adc_channel_sampler;

  localparam int S   = 16;
  localparam int K   = 4;
  localparam int D   = 12;
  localparam int LAT = S + 2 * K * D + 2;

  logic        clk = 1'b0;
  logic        reset, i640, SEL, adc_cs_n, adc_sclk, adc_sdo;
  logic        out_valid, out_ready, busy, ovf, miss, clr_flags;
  logic [6:0]  ADR;
  logic [19:0] out_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  adc_channel_sampler #(
    .SETTLE_CYC(S), .SCLK_DIV(K), .DATA_W(D), .FIFO_AW(3)
  ) dut (
    .clk(clk), .reset(reset), .i640(i640), .ADR(ADR), .SEL(SEL),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_sdo(adc_sdo),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .ovf(ovf), .miss(miss), .clr_flags(clr_flags)
  );

  // ADC model: MSB presented when CS falls, next bit after each SCLK fall
  logic [11:0] cur_word = 12'h000;
  int bit_idx = 0;
  always @(negedge adc_cs_n) bit_idx = 0;
  always @(negedge adc_sclk) bit_idx = bit_idx + 1;
  assign adc_sdo = (bit_idx >= 0 && bit_idx < D) ? cur_word[D-1-bit_idx] : 1'b0;

  // Pin activity monitor
  bit mon_en = 1'b0;
  bit sclk_prev = 1'b0;
  int cs_low = 0, sclk_hi = 0, sclk_rise = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!adc_cs_n) cs_low = cs_low + 1;
      if (adc_sclk) sclk_hi = sclk_hi + 1;
      if (adc_sclk && !sclk_prev) sclk_rise = sclk_rise + 1;
    end
    sclk_prev = adc_sclk;
  end

  // Reference model: ordered queue of expected words, flags
  logic [19:0] q[$];
  bit m_ovf = 1'b0;
  bit m_miss = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [19:0] w, input bit rdy);
    logic [19:0] tmp;
    if (q.size() < 8) begin
      q.push_back(w);
    end else if (rdy) begin
      tmp = q.pop_front();
      q.push_back(w);
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  // One complete conversion; rdy holds out_ready high during the push cycle.
  // pre_valid returns out_valid seen in the push cycle.
  task automatic sample(input logic [6:0] a, input bit s, input bit rdy, output bit pre_valid);
    cur_word = 12'($urandom);
    ADR = a;
    SEL = s;
    i640 = 1'b1;
    tick();
    i640 = 1'b0;
    for (int n = 1; n < LAT - 1; n++) tick();
    chk("busy_at_push", busy, 1);
    pre_valid = out_valid;
    if (rdy) out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    model_push({s, a, cur_word}, rdy);
    chk("idle_after_push", busy, 0);
  endtask

  task automatic pop_check(input string tag);
    logic [19:0] exp;
    chk("model_nonempty", (q.size() > 0), 1);
    exp = (q.size() > 0) ? q.pop_front() : 20'h0;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic clear_flags();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    m_ovf = 1'b0;
    m_miss = 1'b0;
  endtask

  initial begin
    bit pv;
    int lat;
    int n;
    logic [6:0] a;
    bit s;

    reset = 1'b1; i640 = 1'b0; ADR = '0; SEL = 1'b0;
    out_ready = 1'b0; clr_flags = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_cs_n", adc_cs_n, 1);
    chk("rst_sclk", adc_sclk, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_miss", miss, 0);

    // 1: single strobe with fixed pattern, latency and pin shape
    cs_low = 0; sclk_hi = 0; sclk_rise = 0; mon_en = 1'b1;
    cur_word = 12'hA5C;
    ADR = 7'h05; SEL = 1'b1; i640 = 1'b1;
    tick();
    i640 = 1'b0;
    lat = 1;
    while (!out_valid && lat < 300) begin
      tick();
      lat++;
    end
    mon_en = 1'b0;
    chk("t1_latency", lat, LAT);
    chk("t1_data", out_data, 20'h85A5C);
    chk("t1_cs_low", cs_low, 2 * K * D);
    chk("t1_sclk_pulses", sclk_rise, D);
    chk("t1_sclk_high", sclk_hi, K * D);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_empty", out_valid, 0);

    // 2: fill to 8, ninth dropped, drain in order
    for (int i = 0; i < 8; i++) sample(7'(i), 1'($urandom), 1'b0, pv);
    chk("t2_valid_full", out_valid, 1);
    chk("t2_ovf_before", ovf, m_ovf);
    sample(7'd8, 1'($urandom), 1'b0, pv);
    chk("t2_ovf_after", ovf, m_ovf);
    for (int i = 0; i < 8; i++) pop_check("t2_drain");
    chk("t2_empty", out_valid, 0);
    clear_flags();
    chk("t2_ovf_clr", ovf, m_ovf);

    // 3: second strobe 50 cycles in is missed
    cur_word = 12'($urandom);
    a = 7'($urandom); s = 1'($urandom);
    ADR = a; SEL = s; i640 = 1'b1;
    tick();
    i640 = 1'b0;
    repeat (49) tick();
    ADR = ~a; SEL = ~s; i640 = 1'b1;
    tick();
    i640 = 1'b0;
    m_miss = 1'b1;
    n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    chk("t3_done", busy, 0);
    model_push({s, a, cur_word}, 1'b0);
    chk("t3_miss", miss, m_miss);
    pop_check("t3_word");
    chk("t3_one_word", out_valid, 0);
    clear_flags();
    chk("t3_miss_clr", miss, m_miss);

    // 4: reset during conversion
    cur_word = 12'($urandom);
    ADR = 7'($urandom); SEL = 1'($urandom); i640 = 1'b1;
    tick();
    i640 = 1'b0;
    repeat (S + 60) tick();
    chk("t4_cs_low_before", adc_cs_n, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_cs_released", adc_cs_n, 1);
    chk("t4_sclk_low", adc_sclk, 0);
    chk("t4_idle", busy, 0);
    repeat (150) tick();
    chk("t4_no_word", out_valid, 0);
    sample(7'($urandom), 1'($urandom), 1'b0, pv);
    pop_check("t4_next");

    // 5: full FIFO with pop in the push cycle
    for (int i = 0; i < 8; i++) sample(7'($urandom), 1'($urandom), 1'b0, pv);
    sample(7'($urandom), 1'($urandom), 1'b1, pv);
    chk("t5_ovf", ovf, m_ovf);
    for (int i = 0; i < 8; i++) pop_check("t5_drain");
    chk("t5_count8", out_valid, 0);

    // 6: address sweep with bank toggling at wrap
    s = 1'($urandom);
    for (int i = 0; i < 128; i++) begin
      a = 7'(i);
      if (i != 0 && a == 7'd0) s = ~s;
      sample(a, s, 1'b0, pv);
      if (i == 0) chk("t6_latency_valid", {pv, out_valid}, 2'b01);
      pop_check("t6_word");
      repeat ($urandom_range(0, 3)) tick();
    end
    chk("t6_ovf", ovf, m_ovf);
    chk("t6_miss", miss, m_miss);
    chk("t6_empty", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
